// File: rtl/md_ctrl.sv
// Multiply/divide sequencing controller for the E stage: owns HI/LO, the busy
// countdown, the D-stage stall request and the mfhi/mflo read path.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_ok;

    logic             eff;
    logic             eff_md;
    logic             is_div;
    logic [63:0]      mul_res;
    logic [63:0]      div_res;

    // Sign- or zero-extend both operands to 64 bits; the low 64 bits of the
    // product are then correct for both mult and multu.
    function automatic logic [63:0] mul_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic sgn);
        logic signed [63:0] xs;
        logic signed [63:0] ys;
        logic signed [63:0] p;
        xs = sgn ? {{32{x[31]}}, x} : {32'd0, x};
        ys = sgn ? {{32{y[31]}}, y} : {32'd0, y};
        p  = xs * ys;
        return p;
    endfunction

    // Returns {remainder, quotient}. Zero divisor yields a don't-care value that
    // is never committed; the one signed overflow case is pinned explicitly.
    function automatic logic [63:0] div_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic sgn);
        logic signed [31:0] xs;
        logic signed [31:0] ys;
        logic [63:0]        res;
        xs = x;
        ys = y;
        if (y == 32'd0)
            res = '0;
        else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            res = {32'd0, 32'h8000_0000};
        else if (sgn)
            res = {32'(xs % ys), 32'(xs / ys)};
        else
            res = {x % y, x / y};
        return res;
    endfunction

    assign eff     = start & ~cancel & ~busy;
    assign eff_md  = eff & (md_op != 4'd0) & (md_op <= OP_DIVU);
    assign is_div  = (md_op == OP_DIV) | (md_op == OP_DIVU);
    assign mul_res = mul_op(a, b, md_op == OP_MULT);
    assign div_res = div_op(a, b, md_op == OP_DIV);
    assign busy    = (state == RUN);

    always_comb begin
        stall_md = d_is_md & (busy | eff_md);
        md_out   = 32'd0;
        if (md_op == OP_MFHI)
            md_out = hi;
        else if (md_op == OP_MFLO)
            md_out = lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (eff_md) begin
                        pend_hi <= is_div ? div_res[63:32] : mul_res[63:32];
                        pend_lo <= is_div ? div_res[31:0]  : mul_res[31:0];
                        pend_ok <= ~(is_div & (b == 32'd0));
                        count   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state   <= RUN;
                    end else if (eff && md_op == OP_MTHI) begin
                        hi <= a;
                    end else if (eff && md_op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    if (count == CNT_W'(1)) begin
                        count <= '0;
                        state <= IDLE;
                        if (pend_ok) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
